m_layer_5_sched: RTL

//  Sequencer for the conv-layer-5 input map buffer (dual-port RAM, NUM_IN words).

---
 rtl/m_layer_pkg.sv | 27 ++
 rtl/m_layer_5_sched_if.sv | 32 +++
 rtl/m_tag_delay.sv | 29 ++
 rtl/m_layer_5_sched.sv | 103 ++++++++++
 4 files changed

// File: rtl/m_layer_pkg.sv
// Shared definitions for the conv-layer buffer sequencers: FSM states, read-tag
// record and the legal RAM read-latency range.
package m_layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT_ACC,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/m_layer_5_sched_if.sv
// Handshake, RAM-port and kernel-bank signals of the layer-5 buffer sequencer.
interface m_layer_5_sched_if #(
    parameter int AW = 7,
    parameter int PW = 2
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic          acc_ready;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic [PW-1:0] pass_idx;
    logic          busy;
    logic          done;

    modport slave (
        input  start, in_valid, acc_ready,
        output in_ready, ram_we, ram_waddr, ram_re, ram_raddr,
               out_valid, out_first, out_last, pass_idx, busy, done
    );

    modport master (
        output start, in_valid, acc_ready,
        input  in_ready, ram_we, ram_waddr, ram_re, ram_raddr,
               out_valid, out_first, out_last, pass_idx, busy, done
    );
endinterface

// File: rtl/m_tag_delay.sv
// RD_LAT-deep shift register that carries {valid, first, last} alongside the
// RAM read so the tags line up with doutb.
module m_tag_delay
    import m_layer_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk_in,
    input  logic rst,
    input  tag_t tag_d,
    output tag_t tag_q
);

    tag_t [RD_LAT:1] vld_pipe;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= tag_d;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign tag_q = vld_pipe[RD_LAT];

endmodule

// File: rtl/m_layer_5_sched.sv
// Layer-5 input map buffer sequencer: fills NUM_IN words, then replays the
// buffer NUM_PASS times to the kernel bank with first/last/pass tags.
module m_layer_5_sched
    import m_layer_pkg::*;
#(
    parameter int NUM_IN   = 120,
    parameter int AW       = 7,
    parameter int NUM_PASS = 4,
    parameter int PW       = 2,
    parameter int RD_LAT   = 1
) (
    input  logic                clk_in,
    input  logic                rst,
    m_layer_5_sched_if.slave    bus
);

    localparam logic [AW-1:0] LAST_W = AW'(NUM_IN - 1);
    localparam logic [PW-1:0] LAST_P = PW'(NUM_PASS - 1);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("m_layer_5_sched: RD_LAT out of range");
    end

    state_t        state, state_nxt;
    logic [AW-1:0] wcnt, rcnt;
    logic [PW-1:0] pass_q;
    logic          in_ready_q;
    logic          accept, wlast, rlast, rd_en;
    tag_t          tag_d, tag_q;

    assign accept = bus.in_valid & in_ready_q;
    assign wlast  = accept && (wcnt == LAST_W);
    assign rlast  = (rcnt == LAST_W);
    assign rd_en  = (state == ST_READ);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.start) state_nxt = ST_FILL;
            ST_FILL:     if (wlast) state_nxt = ST_WAIT_ACC;
            ST_WAIT_ACC: if (bus.acc_ready) state_nxt = ST_READ;
            ST_READ:     if (rlast) state_nxt = ST_DRAIN;
            // Leave only once the final tagged word has come out of the delay line.
            ST_DRAIN:    if (tag_q.last) state_nxt = (pass_q == LAST_P) ? ST_DONE : ST_WAIT_ACC;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // in_ready is registered, so it drops the cycle after the final word.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) in_ready_q <= 1'b0;
        else     in_ready_q <= (state == ST_FILL) && !wlast;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                                wcnt <= '0;
        else if (state == ST_IDLE && bus.start) wcnt <= '0;
        else if (accept && wcnt != LAST_W)      wcnt <= wcnt + 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                                       rcnt <= '0;
        else if (state == ST_WAIT_ACC && bus.acc_ready) rcnt <= '0;
        else if (rd_en && !rlast)                      rcnt <= rcnt + 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                                 pass_q <= '0;
        else if (state == ST_IDLE && bus.start)  pass_q <= '0;
        else if (state == ST_DRAIN && tag_q.last && pass_q != LAST_P)
                                                 pass_q <= pass_q + 1'b1;
    end

    assign tag_d = '{valid: rd_en,
                     first: rd_en && (rcnt == '0),
                     last:  rd_en && rlast};

    m_tag_delay #(.RD_LAT(RD_LAT)) u_tag_delay (
        .clk_in (clk_in),
        .rst    (rst),
        .tag_d  (tag_d),
        .tag_q  (tag_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_we    = accept;
    assign bus.ram_waddr = wcnt;
    assign bus.ram_re    = rd_en;
    assign bus.ram_raddr = rcnt;
    assign bus.out_valid = tag_q.valid;
    assign bus.out_first = tag_q.first;
    assign bus.out_last  = tag_q.last;
    assign bus.pass_idx  = pass_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

endmodule
